// File: rtl/byte_stream_scoreboard.sv
// Byte-stream scoreboard: buffers an unthrottled byte stream in a small FIFO, drains it on
// drain_en, and checks ordering (sequence tags) and checksums to produce sticky passed/failed.
module byte_stream_scoreboard #(
  parameter int DEPTH      = 8,
  parameter int PASS_COUNT = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     drain_en,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drained_cnt,
  output logic                     passed,
  output logic                     failed,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // Handshake: in_valid has no ready; a byte offered while full with no pop is lost
  // and counts as overflow. drain_en is a request; out_valid reports the pop one cycle later.

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [3:0]      push_seq_q, push_seq_d;
  logic [3:0]      pop_seq_q, pop_seq_d;
  logic [15:0]     in_sum_q, in_sum_d;
  logic [15:0]     out_sum_q, out_sum_d;
  logic [15:0]     drained_q, drained_d;
  logic [15:0]     cycle_q, cycle_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;

  logic [11:0]     mem_q [DEPTH];

  logic            run;
  logic            full;
  logic            pop;
  logic            push;
  logic            overflow;
  logic            tag_err;
  logic            timeout_hit;
  logic            pass_cond;
  logic [11:0]     rd_entry;

  always_comb begin
    run         = (state_q == ST_RUN);
    full        = (occ_q == OW'(DEPTH));
    pop         = drain_en && (occ_q != '0) && run;
    push        = in_valid && run && (!full || pop);
    overflow    = in_valid && run && full && !pop;
    rd_entry    = mem_q[rd_ptr_q];
    tag_err     = pop && (rd_entry[11:8] != pop_seq_q);
    timeout_hit = run && ((32'(cycle_q) + 32'd1) >= 32'(TIMEOUT));
    pass_cond   = (32'(drained_q) >= 32'(PASS_COUNT)) && (occ_q == '0) &&
                  (in_sum_q == out_sum_q);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    push_seq_d  = push_seq_q;
    pop_seq_d   = pop_seq_q;
    in_sum_d    = in_sum_q;
    out_sum_d   = out_sum_q;
    drained_d   = drained_q;
    cycle_d     = cycle_q;
    out_valid_d = pop;
    out_data_d  = pop ? rd_entry[7:0] : 8'd0;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      push_seq_d = push_seq_q + 4'd1;
      in_sum_d   = in_sum_q + {8'd0, in_data};
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      pop_seq_d = pop_seq_q + 4'd1;
      out_sum_d = out_sum_q + {8'd0, rd_entry[7:0]};
      if (drained_q != 16'hFFFF) drained_d = drained_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (run && cycle_q != 16'hFFFF) cycle_d = cycle_q + 16'd1;

    // Any failure in the same cycle as the pass condition wins.
    if (run) begin
      if (overflow || tag_err || timeout_hit) state_d = ST_FAIL;
      else if (pass_cond)                     state_d = ST_PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      push_seq_q  <= '0;
      pop_seq_q   <= '0;
      in_sum_q    <= '0;
      out_sum_q   <= '0;
      drained_q   <= '0;
      cycle_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      push_seq_q  <= push_seq_d;
      pop_seq_q   <= pop_seq_d;
      in_sum_q    <= in_sum_d;
      out_sum_q   <= out_sum_d;
      drained_q   <= drained_d;
      cycle_q     <= cycle_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {push_seq_q, in_data};
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign occupancy   = occ_q;
  assign drained_cnt = drained_q;
  assign passed      = (state_q == ST_PASS);
  assign failed      = (state_q == ST_FAIL);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_byte_stream_scoreboard.sv
// Directed bench for byte_stream_scoreboard: reset, steady stream, full/overflow,
// bubbles with a scoreboard queue, timeout, and reset mid-run.
module tb_byte_stream_scoreboard;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        drain_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  occupancy;
  logic [15:0] drained_cnt;
  logic        passed;
  logic        failed;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  byte_stream_scoreboard #(.DEPTH(8), .PASS_COUNT(16), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .drain_en(drain_en), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .drained_cnt(drained_cnt), .passed(passed),
    .failed(failed), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0; drain_en = 1'b0; in_data = 8'd0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; drain_en = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (occupancy !== 4'd0) begin n_errors++; $display("FAIL reset_occ[%0d]: got %0d expected 0", i, occupancy); end
      n_checks++;
      if ({out_valid, passed, failed} !== 3'b000) begin n_errors++; $display("FAIL reset_flags[%0d]: got %b expected 000", i, {out_valid, passed, failed}); end
    end
    reset = 1'b0; in_valid = 1'b0; drain_en = 1'b0;
    step();
    n_checks++;
    if ({occupancy, drained_cnt} !== 20'd0) begin n_errors++; $display("FAIL reset_release_cnt: occ %0d drained %0d expected 0 0", occupancy, drained_cnt); end
    n_checks++;
    if ({out_valid, out_data, passed, failed} !== 11'd0) begin n_errors++; $display("FAIL reset_release_out: got %b expected 0", {out_valid, out_data, passed, failed}); end
  endtask

  // Bytes 0x01..0x10 with drain every cycle, starting on the first edge after reset.
  task automatic run_stream(input string tag);
    logic [15:0] sum;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [3:0]  e_occ;
    logic [15:0] e_drained;
    sum = 16'd0;
    for (int k = 1; k <= 20; k++) begin
      in_valid = (k <= 16);
      in_data  = 8'(k);
      drain_en = 1'b1;
      step();
      e_valid   = (k >= 2 && k <= 17);
      e_data    = e_valid ? 8'(k - 1) : 8'd0;
      e_occ     = (k <= 16) ? 4'd1 : 4'd0;
      e_drained = (k < 2) ? 16'd0 : ((k > 17) ? 16'd16 : 16'(k - 1));
      if (out_valid) sum = sum + {8'd0, out_data};
      n_checks++;
      if ({out_valid, out_data} !== {e_valid, e_data}) begin n_errors++; $display("FAIL %s_out[%0d]: got %b/%h expected %b/%h", tag, k, out_valid, out_data, e_valid, e_data); end
      n_checks++;
      if (occupancy !== e_occ) begin n_errors++; $display("FAIL %s_occ[%0d]: got %0d expected %0d", tag, k, occupancy, e_occ); end
      n_checks++;
      if (drained_cnt !== e_drained) begin n_errors++; $display("FAIL %s_drained[%0d]: got %0d expected %0d", tag, k, drained_cnt, e_drained); end
      n_checks++;
      if ({passed, failed} !== {(k >= 18), 1'b0}) begin n_errors++; $display("FAIL %s_pf[%0d]: got %b%b expected %b0", tag, k, passed, failed, (k >= 18)); end
    end
    n_checks++;
    if (sum !== 16'h0088) begin n_errors++; $display("FAIL %s_sum: got %h expected 0088", tag, sum); end
    n_checks++;
    if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL %s_state: got %0d expected 1", tag, dbg_state); end
  endtask

  task automatic test_steady_stream();
    do_reset(2);
    run_stream("stream");
  endtask

  task automatic test_fill_full();
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; drain_en = 1'b0; in_data = 8'h10 + 8'(i);
      step();
    end
    n_checks++;
    if ({occupancy, failed} !== {4'd8, 1'b0}) begin n_errors++; $display("FAIL full_occ: got %0d/%b expected 8/0", occupancy, failed); end
    in_valid = 1'b1; drain_en = 1'b1; in_data = 8'h18;
    step();
    n_checks++;
    if ({occupancy, failed} !== {4'd8, 1'b0}) begin n_errors++; $display("FAIL full_pushpop: got %0d/%b expected 8/0", occupancy, failed); end
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h10}) begin n_errors++; $display("FAIL full_pop_data: got %b/%h expected 1/10", out_valid, out_data); end
    in_valid = 1'b1; drain_en = 1'b0; in_data = 8'h19;
    step();
    n_checks++;
    if ({failed, passed, out_valid} !== 3'b100) begin n_errors++; $display("FAIL overflow_flags: got %b expected 100", {failed, passed, out_valid}); end
    n_checks++;
    if (occupancy !== 4'd8) begin n_errors++; $display("FAIL overflow_occ: got %0d expected 8", occupancy); end
    in_valid = 1'b1; drain_en = 1'b1;
    step();
    n_checks++;
    if ({failed, out_valid, occupancy, dbg_state} !== {1'b1, 1'b0, 4'd8, 2'd2}) begin n_errors++; $display("FAIL fail_sticky: got %b %b %0d %0d expected 1 0 8 2", failed, out_valid, occupancy, dbg_state); end
  endtask

  task automatic test_bubbles();
    int   m_occ;
    int   m_drained;
    bit   m_pass;
    bit   vld;
    bit   drn;
    bit   m_pop;
    bit   m_push;
    bit   pass_next;
    logic [7:0] b;
    logic [7:0] e_byte;
    do_reset(2);
    exp_q.delete();
    m_occ = 0; m_drained = 0; m_pass = 1'b0; e_byte = 8'd0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      drn = (cyc < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      vld = (cyc < 200) ? 1'($urandom_range(0, 1)) : (m_drained < 20);
      // Keep the FIFO non-empty until tags have wrapped, so PASS cannot come early.
      if (m_occ <= 1 && m_drained < 20) drn = 1'b0;
      if (m_occ == 8 && !drn) vld = 1'b0;
      b = 8'($urandom_range(0, 255));
      m_pop     = !m_pass && drn && (m_occ != 0);
      m_push    = !m_pass && vld && (m_occ < 8 || m_pop);
      pass_next = !m_pass && (m_drained >= 16) && (m_occ == 0);
      in_valid = vld; drain_en = drn; in_data = b;
      step();
      if (m_push) exp_q.push_back(b);
      if (m_pop) e_byte = exp_q.pop_front();
      m_occ     = m_occ + int'(m_push) - int'(m_pop);
      m_drained = m_drained + int'(m_pop);
      m_pass    = m_pass | pass_next;
      n_checks++;
      if (out_valid !== m_pop) begin n_errors++; $display("FAIL bub_valid[%0d]: got %b expected %b", cyc, out_valid, m_pop); end
      if (m_pop) begin
        n_checks++;
        if (out_data !== e_byte) begin n_errors++; $display("FAIL bub_data[%0d]: got %h expected %h", cyc, out_data, e_byte); end
      end
      n_checks++;
      if (occupancy !== 4'(m_occ)) begin n_errors++; $display("FAIL bub_occ[%0d]: got %0d expected %0d", cyc, occupancy, m_occ); end
      n_checks++;
      if ({passed, failed} !== {m_pass, 1'b0}) begin n_errors++; $display("FAIL bub_pf[%0d]: got %b%b expected %b0", cyc, passed, failed, m_pass); end
    end
    n_checks++;
    if ({passed, failed} !== 2'b10) begin n_errors++; $display("FAIL bub_final: got %b%b expected 10", passed, failed); end
  endtask

  task automatic test_timeout();
    do_reset(2);
    in_valid = 1'b0; drain_en = 1'b1;
    repeat (999) step();
    n_checks++;
    if ({passed, failed} !== 2'b00) begin n_errors++; $display("FAIL timeout_early: got %b%b expected 00", passed, failed); end
    step();
    n_checks++;
    if ({passed, failed} !== 2'b01) begin n_errors++; $display("FAIL timeout_hit: got %b%b expected 01", passed, failed); end
  endtask

  task automatic test_reset_mid_run();
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; drain_en = 1'b0; in_data = 8'h40 + 8'(i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; drain_en = 1'b1; in_data = 8'h50 + 8'(i);
      step();
    end
    n_checks++;
    if ({occupancy, drained_cnt} !== {4'd5, 16'd2}) begin n_errors++; $display("FAIL mid_pre: occ %0d drained %0d expected 5 2", occupancy, drained_cnt); end
    reset = 1'b1; in_valid = 1'b1; drain_en = 1'b1;
    step();
    n_checks++;
    if ({occupancy, drained_cnt} !== 20'd0) begin n_errors++; $display("FAIL mid_reset_cnt: occ %0d drained %0d expected 0 0", occupancy, drained_cnt); end
    n_checks++;
    if ({out_valid, out_data, passed, failed} !== 11'd0) begin n_errors++; $display("FAIL mid_reset_out: got %b expected 0", {out_valid, out_data, passed, failed}); end
    reset = 1'b0;
    run_stream("mid_stream");
  endtask

  initial begin
    test_reset();
    test_steady_stream();
    test_fill_full();
    test_bubbles();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/byte_stream_scoreboard.md
Name: byte_stream_scoreboard

Overview:
- Sits directly downstream of the random valid/data transaction generator in the test DUT.
- Accepts one byte per cycle on in_valid/in_data with no backpressure to the source, buffers it in a small FIFO, and drains it under a random drain enable.
- Checks ordering and checksum consistency between the push and pop sides.
- Drives the DUT-level passed/failed outputs in place of the bare cycle-count pass condition.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, 2..64.
- PASS_COUNT, 16, number of drained bytes required before passed may assert.
- TIMEOUT, 1000, cycles after reset by which passed must assert, else failed.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  byte present this cycle.
- in_data  input  8  byte payload; don't-care when in_valid=0.
- drain_en  input  1  consumer requests a pop this cycle (random bit in test DUT).
- out_valid  output  1  a byte is popped this cycle.
- out_data  output  8  popped byte; 0 when out_valid=0.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.
- drained_cnt  output  16  total bytes popped since reset (saturating).
- passed  output  1  sticky pass.
- failed  output  1  sticky fail.

Behaviour:
- One clock domain. reset is synchronous and active-high.
- Reset clears everything: occupancy, drained_cnt, out_valid, out_data, passed, failed, both checksums, both sequence tags, cycle counter; state=RUN.
- Reset asserted mid-operation discards FIFO contents; all outputs are 0 the cycle after reset is sampled.
- FIFO:
  - Circular buffer, DEPTH entries of {tag[3:0], data[7:0]}.
  - Write and read pointers wrap modulo DEPTH.
- Pop:
  - pop = drain_en && occupancy!=0 && state==RUN.
  - Registered output: out_valid/out_data reflect the pop decided in the previous cycle (1-cycle latency from drain_en to out_valid).
  - No bypass: a byte pushed in cycle N is poppable no earlier than cycle N+1, and appears on out_valid at N+2 at the earliest.
- Push:
  - push = in_valid && state==RUN && (occupancy<DEPTH || pop).
  - A push into a full FIFO with a simultaneous pop is accepted; occupancy is unchanged.
  - Each push stores tag=push_seq, then increments push_seq (4-bit wrap).
  - Each push adds in_data into in_sum (16-bit, wrap).
- Overflow: in_valid while occupancy==DEPTH and no pop -> byte dropped; state->FAIL next cycle.
- Pop checks:
  - Each pop compares the stored tag with pop_seq; a mismatch -> FAIL.
  - pop_seq increments on every pop (4-bit wrap).
  - Each pop adds data into out_sum (16-bit, wrap).
  - drained_cnt increments per pop, saturating at 16'hFFFF.
- State machine, states RUN, PASS, FAIL:
  - RUN->PASS when drained_cnt>=PASS_COUNT && occupancy==0 && in_sum==out_sum, evaluated on registered values.
  - RUN->FAIL on overflow, tag mismatch, or cycle counter reaching TIMEOUT while in RUN.
  - FAIL has priority when a FAIL condition and the PASS condition are both true in the same cycle.
  - PASS and FAIL are terminal until reset. No push or pop occurs in either; in_valid is ignored.
- Outputs: passed = (state==PASS), failed = (state==FAIL), registered; never both 1.
- Cycle counter: 16 bits, saturating; counts only in RUN.

Test Plan:
- Reset check: reset held 3 cycles, in_valid=1 -> occupancy=0, passed=failed=0, out_valid=0 throughout and the cycle after release.
- Steady stream: in_valid=1 and drain_en=1 every cycle, data 0x01..0x10 -> out_data 0x01..0x10 in order starting 2 cycles after the first push; passed=1 once 16 bytes are drained and the FIFO is empty; in_sum=out_sum=0x0088.
- Fill to full: drain_en=0, push 8 bytes -> occupancy=8. 9th in_valid with drain_en=1 the same cycle is accepted, occupancy stays 8, failed=0. A 10th in_valid with drain_en=0 -> failed=1 next cycle.
- Bubbles: random in_valid/drain_en at roughly 50% each for 200 cycles with DEPTH=8 -> ordering preserved, sequence tags wrap past 15 without a mismatch, passed eventually 1, never failed.
- Timeout: in_valid=0 forever -> failed=1 exactly when the cycle counter reaches 1000; passed stays 0.
- Reset mid-run: reset asserted with occupancy=5 -> occupancy=0 and drained_cnt=0 next cycle; the subsequent stream passes normally.
